fpga_sram_dp_ex: RTL

Parametrised simple-dual-port FPGA block RAM: one write port with byte enables and one read port. The read path is registered, with an optional second output stage, same-cycle write-to-read forwarding and a read-valid strobe. An optional power-on clear sequencer zeroes the array after reset. It replaces the fixed 32-bit dual-port RAM wrapper in the SoC RAM wrap layer for instruction/data/scratch memories that need wider words or deterministic contents.

---
 rtl/fpga_sram_dp_ex_if.sv | 27 ++
 rtl/fpga_sram_dp_ex.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fpga_sram_dp_ex_if.sv
// Bus bundle for the simple-dual-port RAM: one byte-enabled write port, one read port,
// plus the init-done status.
interface fpga_sram_dp_ex_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
);
  localparam int unsigned NB = DW / 8;

  logic [AW-1:0] ram_raddr;
  logic          ram_ren;
  logic [DW-1:0] ram_rdata;
  logic          ram_rvalid;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [NB-1:0] ram_wen;
  logic          init_done;

  modport master (
    output ram_raddr, ram_ren, ram_waddr, ram_wdata, ram_wen,
    input  ram_rdata, ram_rvalid, init_done
  );

  modport slave (
    input  ram_raddr, ram_ren, ram_waddr, ram_wdata, ram_wen,
    output ram_rdata, ram_rvalid, init_done
  );
endinterface

// File: rtl/fpga_sram_dp_ex.sv
// Simple-dual-port block RAM with byte enables, write-first forwarding and optional output stage.
// Define FPGA_SRAM_DP_INIT_CLEAR_EN to build the power-on clear sequencer.
module fpga_sram_dp_ex #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                 CLK,
  input  logic                 resetn,
  fpga_sram_dp_ex_if.slave     ram
);
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem [Depth];

  logic          init_done;
  logic          clear_we;
  logic [AW-1:0] clear_addr;
  logic [NB-1:0] mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

`ifdef FPGA_SRAM_DP_INIT_CLEAR_EN
  typedef enum logic {StClear, StReady} state_e;

  state_e      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StClear: begin
        if (cnt_q[AW]) state_d = StReady;
        else           cnt_d   = cnt_q + 1'b1;
      end
      StReady: state_d = StReady;
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    init_done  = (state_q == StReady);
    clear_we   = (state_q == StClear) && !cnt_q[AW];
    clear_addr = cnt_q[AW-1:0];
  end
`else
  logic init_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) init_q <= 1'b0;
    else         init_q <= 1'b1;
  end

  always_comb begin
    init_done  = init_q;
    clear_we   = 1'b0;
    clear_addr = '0;
  end
`endif

  // User writes are gated until the RAM is ready; the clear sequencer owns the port before that.
  always_comb begin
    mem_we    = '0;
    mem_waddr = ram.ram_waddr;
    mem_wdata = ram.ram_wdata;
    if (clear_we) begin
      mem_we    = '1;
      mem_waddr = clear_addr;
      mem_wdata = '0;
    end else if (init_done) begin
      mem_we = ram.ram_wen;
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  logic          rd_fire;
  logic          rd_hit;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;

  assign rd_fire = ram.ram_ren & init_done;
  assign rd_hit  = (ram.ram_waddr == ram.ram_raddr);

  // Write-first per lane on a same-address collision.
  always_comb begin
    rd_word = mem[ram.ram_raddr];
    for (int i = 0; i < NB; i++) begin
      if (rd_hit && ram.ram_wen[i]) rd_word[8*i +: 8] = ram.ram_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_data_q <= rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] out_data_q;
    logic          out_valid_q;

    always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) out_data_q <= rd_data_q;
      end
    end

    assign ram.ram_rdata  = out_data_q;
    assign ram.ram_rvalid = out_valid_q;
  end else begin : g_no_out_reg
    assign ram.ram_rdata  = rd_data_q;
    assign ram.ram_rvalid = rd_valid_q;
  end

  assign ram.init_done = init_done;
endmodule
